dut_batch_seq: RTL

//  Upstream feeder for the AES core. Runs cfg_count back-to-back encryptions from a single start.

---
 rtl/dut_batch_pkg.sv | 20 ++
 rtl/dut_batch_timer.sv | 34 +++
 rtl/dut_batch_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dut_batch_pkg.sv
// Shared definitions for the AES batch sequencer.
// Contents: block width, default parameter values, FSM state encoding.
package dut_batch_pkg;

   localparam int unsigned BLOCK_W     = 128;
   localparam int unsigned CNT_W_DEF   = 16;
   localparam int unsigned GAP_W_DEF   = 8;
   localparam int unsigned TIMEOUT_DEF = 8;
   localparam int unsigned STATE_W     = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_RUN       = 3'd3,
      ST_GAP       = 3'd4,
      ST_DONE      = 3'd5
   } state_t;

endpackage

// File: rtl/dut_batch_timer.sv
// Shared down-counter used for both the inter-encryption gap and the busy-rise timeout.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       load counter with load_val (has priority over en)
//   load_val   value to load
//   en         decrement by one (saturates at zero)
//   zero_c     counter is zero (decoded from the count register)
module dut_batch_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero_c
);

   logic [W-1:0] cnt;

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero_c = (cnt == '0);

endmodule

// File: rtl/dut_batch_seq.sv
// AES batch sequencer: runs cfg_count chained encryptions (plaintext = previous ciphertext)
// from a single start pulse, with a programmable idle gap and a busy-rise timeout.
// Ports:
//   dut_clk, dut_rst            clock, asynchronous active-high reset
//   cfg_start/abort/count/gap   batch control (count, gap, key, pt sampled on accepted start)
//   cfg_key, cfg_pt             key and first plaintext
//   aes_load/key/data           load strobe and operands to the AES core
//   aes_busy, aes_ct            core status and ciphertext (valid on busy fall)
//   batch_busy/done/cnt/err     batch status; err is a sticky busy-rise timeout
//   last_ct                     most recent ciphertext
//   trigger                     registered aes_busy qualified by batch_busy
// Build option BATCH_TVLA_EN: adds cfg_fixed_pt and batch_class; odd-indexed encryptions
//   use the fixed plaintext and the chain advances only on even-indexed ciphertexts.
module dut_batch_seq
   import dut_batch_pkg::*;
#(
   parameter int unsigned pCNT_WIDTH = CNT_W_DEF,
   parameter int unsigned pGAP_WIDTH = GAP_W_DEF,
   parameter int unsigned pTIMEOUT   = TIMEOUT_DEF
) (
   input  logic                  dut_clk,
   input  logic                  dut_rst,
   input  logic                  cfg_start,
   input  logic                  cfg_abort,
   input  logic [pCNT_WIDTH-1:0] cfg_count,
   input  logic [pGAP_WIDTH-1:0] cfg_gap,
   input  logic [BLOCK_W-1:0]    cfg_key,
   input  logic [BLOCK_W-1:0]    cfg_pt,
`ifdef BATCH_TVLA_EN
   input  logic [BLOCK_W-1:0]    cfg_fixed_pt,
   output logic                  batch_class,
`endif
   output logic                  aes_load,
   output logic [BLOCK_W-1:0]    aes_key,
   output logic [BLOCK_W-1:0]    aes_data,
   input  logic                  aes_busy,
   input  logic [BLOCK_W-1:0]    aes_ct,
   output logic                  batch_busy,
   output logic                  batch_done,
   output logic [pCNT_WIDTH-1:0] batch_cnt,
   output logic                  batch_err,
   output logic [BLOCK_W-1:0]    last_ct,
   output logic                  trigger
);

   localparam int unsigned TO_W  = $clog2(pTIMEOUT + 1);
   localparam int unsigned TMR_W = (pGAP_WIDTH > TO_W) ? pGAP_WIDTH : TO_W;

   state_t                state, state_n;
   logic [pCNT_WIDTH-1:0] count_q;
   logic [pCNT_WIDTH-1:0] cnt_inc;
   logic [pGAP_WIDTH-1:0] gap_q;
   logic                  busy_q;
   logic                  accept, capture, set_err;
   logic                  tmr_load, tmr_en, tmr_zero;
   logic [TMR_W-1:0]      tmr_val;
`ifdef BATCH_TVLA_EN
   logic [BLOCK_W-1:0]    chain_q;
   logic [BLOCK_W-1:0]    fixed_q;
`endif

   assign cnt_inc = batch_cnt + pCNT_WIDTH'(1);

   dut_batch_timer #(.W(TMR_W)) u_timer (
      .clk      (dut_clk),
      .rst      (dut_rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .zero_c   (tmr_zero)
   );

   // State register
   always_ff @(posedge dut_clk or posedge dut_rst) begin
      if (dut_rst) state <= ST_IDLE;
      else         state <= state_n;
   end

   // Next-state and control strobes
   always_comb begin
      state_n  = state;
      accept   = 1'b0;
      capture  = 1'b0;
      set_err  = 1'b0;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      tmr_val  = '0;
      unique case (state)
         ST_IDLE: begin
            if (cfg_start) begin
               accept  = 1'b1;
               state_n = (cfg_count == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            // Timer counts TIMEOUT cycles of WAIT_BUSY: values TIMEOUT-1 down to 0
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(pTIMEOUT - 1);
            state_n  = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (aes_busy) begin
               state_n = ST_RUN;
            end else if (tmr_zero) begin
               set_err = 1'b1;
               state_n = ST_DONE;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_RUN: begin
            if (busy_q && !aes_busy) begin
               capture = 1'b1;
               if ((cnt_inc == count_q) || cfg_abort) begin
                  state_n = ST_DONE;
               end else if (gap_q == '0) begin
                  state_n = ST_LOAD;
               end else begin
                  tmr_load = 1'b1;
                  tmr_val  = TMR_W'(gap_q) - TMR_W'(1);
                  state_n  = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (cfg_abort)     state_n = ST_DONE;
            else if (tmr_zero) state_n = ST_LOAD;
            else               tmr_en  = 1'b1;
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge dut_clk or posedge dut_rst) begin
      if (dut_rst) begin
         busy_q     <= 1'b0;
         trigger    <= 1'b0;
         aes_load   <= 1'b0;
         aes_key    <= '0;
         aes_data   <= '0;
         batch_busy <= 1'b0;
         batch_done <= 1'b0;
         batch_cnt  <= '0;
         batch_err  <= 1'b0;
         last_ct    <= '0;
         count_q    <= '0;
         gap_q      <= '0;
`ifdef BATCH_TVLA_EN
         chain_q     <= '0;
         fixed_q     <= '0;
         batch_class <= 1'b0;
`endif
      end else begin
         busy_q     <= aes_busy;
         trigger    <= batch_busy & aes_busy;
         aes_load   <= (state == ST_LOAD);
         batch_done <= (state == ST_DONE);
         if (accept) begin
            count_q    <= cfg_count;
            gap_q      <= cfg_gap;
            aes_key    <= cfg_key;
            aes_data   <= cfg_pt;
            batch_cnt  <= '0;
            batch_err  <= 1'b0;
            batch_busy <= 1'b1;
`ifdef BATCH_TVLA_EN
            chain_q     <= cfg_pt;
            fixed_q     <= cfg_fixed_pt;
            batch_class <= 1'b0;
`endif
         end
         if (set_err) batch_err <= 1'b1;
         if (capture) begin
            last_ct   <= aes_ct;
            batch_cnt <= cnt_inc;
`ifdef BATCH_TVLA_EN
            // batch_cnt is the index of the encryption just completed
            if (!batch_cnt[0]) begin
               chain_q     <= aes_ct;
               aes_data    <= fixed_q;
               batch_class <= 1'b1;
            end else begin
               aes_data    <= chain_q;
               batch_class <= 1'b0;
            end
`else
            aes_data <= aes_ct;
`endif
         end
         if (state == ST_DONE) batch_busy <= 1'b0;
      end
   end

endmodule
